// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: ALU op codes, sequencer
// states and the default fixed-point scale (two decimal places).
package calc_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_MUL = 2'd2,
        ALU_DIV = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_MUL    = 2'd1,
        SEQ_DIV    = 2'd2,
        SEQ_FINISH = 2'd3
    } seq_state_e;

    localparam int unsigned CALC_FRAC_SCALE = 100;

endpackage

// File: rtl/seq_restoring_divider.sv
// Restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient
// bit per enabled step, MSB first. load_i captures the dividend and clears
// the partial remainder; divisor_i must be held stable while stepping.
module seq_restoring_divider #(
    parameter int WIDTH = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [2*WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0]   remainder_o
);

    logic [2*WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   diff;
    logic               fits;

    // Partial remainder shifted left with the next dividend bit brought in.
    // The remainder is always below the divisor, so the low WIDTH bits of the
    // subtraction are exact whenever the trial fits.
    assign trial = {rem_q, quot_q[2*WIDTH-1]};
    assign fits  = (trial >= {1'b0, divisor_i});
    assign diff  = trial[WIDTH-1:0] - divisor_i;

    // Next-state: load clears the remainder; each step retires one quotient bit.
    always_comb begin
        quot_d = quot_q;
        rem_d  = rem_q;
        if (load_i) begin
            quot_d = dividend_i;
            rem_d  = '0;
        end else if (step_i) begin
            quot_d = {quot_q[2*WIDTH-2:0], fits};
            rem_d  = fits ? diff : trial[WIDTH-1:0];
        end
    end

    // Quotient shift register and partial remainder.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
        end
    end

    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle signed fixed-point ALU behind a start/done handshake.
// Add/sub complete in one cycle; mul and div share a WIDTH-cycle shift-add
// multiplier phase followed by a 2*WIDTH-cycle restoring division phase,
// then a one-cycle sign/saturation step.
// Build option: define ALU_SEQUENCER_ROUND_EN to round the mul/div quotient
// half away from zero instead of truncating (latency unchanged).
module alu_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int FRAC_SCALE = CALC_FRAC_SCALE
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic signed [WIDTH-1:0] operand_a,
    input  logic signed [WIDTH-1:0] operand_b,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] result,
    output logic                    error
);

    localparam int CNT_W = $clog2(2 * WIDTH);
    localparam logic [WIDTH-1:0]   SCALE_W = WIDTH'(FRAC_SCALE);
    localparam logic [WIDTH-1:0]   MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH:0]   MAG_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};

    seq_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic signed [WIDTH-1:0] result_q, result_d;
    logic                 error_q, error_d;
    logic                 done_q, done_d;

    alu_op_e              op_e;
    logic signed [WIDTH-1:0] add_res, sub_res;
    logic                 add_ovf, sub_ovf;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [2*WIDTH-1:0]   prod_acc;
    logic                 div_load, div_step;
    logic [2*WIDTH-1:0]   div_quot;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH:0]     fin_mag;
    logic [WIDTH-1:0]     fin_res;
    logic                 fin_err;

    // Clamp an unsigned magnitude into the signed result range and apply the
    // sign; returns {error, result}.
    function automatic logic [WIDTH:0] saturate(input logic [2*WIDTH:0] mag,
                                                input logic neg);
        logic [WIDTH-1:0] low;
        low = mag[WIDTH-1:0];
        if (mag > MAG_MAX) begin
            return neg ? {1'b1, MIN_NEG} : {1'b1, MAX_POS};
        end
        return {1'b0, neg ? (~low + 1'b1) : low};
    endfunction

`ifdef ALU_SEQUENCER_ROUND_EN
    // Round half away from zero: bump the magnitude when the leftover is at
    // least half the divisor. The sign is applied afterwards.
    function automatic logic [2*WIDTH:0] round_mag(input logic [2*WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] r,
                                                   input logic [WIDTH-1:0] d);
        if ({r, 1'b0} >= {1'b0, d}) begin
            return {1'b0, q} + (2*WIDTH+1)'(1);
        end
        return {1'b0, q};
    endfunction

    assign fin_mag = round_mag(div_quot, div_rem, divisor_q);
`else
    logic unused_rem;
    assign fin_mag    = {1'b0, div_quot};
    assign unused_rem = ^div_rem;
`endif

    assign op_e    = alu_op_e'(op);
    assign add_res = operand_a + operand_b;
    assign sub_res = operand_a - operand_b;
    assign add_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                     (add_res[WIDTH-1] != operand_a[WIDTH-1]);
    assign sub_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                     (sub_res[WIDTH-1] != operand_a[WIDTH-1]);
    assign abs_a   = operand_a[WIDTH-1] ? $unsigned(-operand_a) : $unsigned(operand_a);
    assign abs_b   = operand_b[WIDTH-1] ? $unsigned(-operand_b) : $unsigned(operand_b);

    // Shift-add: the multiplicand moves left while the multiplier moves right,
    // so bit 0 of the multiplier always selects the current partial product.
    assign prod_acc = prod_q + (mplier_q[0] ? mcand_q : '0);

    assign {fin_err, fin_res} = saturate(fin_mag, sign_q);

    seq_restoring_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clock       (clock),
        .reset       (reset),
        .load_i      (div_load),
        .step_i      (div_step),
        .dividend_i  (prod_acc),
        .divisor_i   (divisor_q),
        .quotient_o  (div_quot),
        .remainder_o (div_rem)
    );

    // Next-state and output decode for the sequencer FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        error_d   = error_q;
        done_d    = 1'b0;
        div_load  = 1'b0;
        div_step  = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (start && !abort) begin
                    case (op_e)
                        ALU_ADD: begin
                            result_d = add_res;
                            error_d  = add_ovf;
                            done_d   = 1'b1;
                        end
                        ALU_SUB: begin
                            result_d = sub_res;
                            error_d  = sub_ovf;
                            done_d   = 1'b1;
                        end
                        default: begin
                            if (op_e == ALU_DIV && operand_b == '0) begin
                                result_d = '0;
                                error_d  = 1'b1;
                                done_d   = 1'b1;
                            end else begin
                                state_d   = SEQ_MUL;
                                cnt_d     = '0;
                                sign_d    = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                                mcand_d   = {{WIDTH{1'b0}}, abs_a};
                                mplier_d  = (op_e == ALU_MUL) ? abs_b : SCALE_W;
                                divisor_d = (op_e == ALU_MUL) ? SCALE_W : abs_b;
                                prod_d    = '0;
                            end
                        end
                    endcase
                end
            end

            SEQ_MUL: begin
                if (abort) begin
                    state_d = SEQ_IDLE;
                end else begin
                    prod_d   = prod_acc;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = SEQ_DIV;
                        cnt_d    = '0;
                        div_load = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            SEQ_DIV: begin
                if (abort) begin
                    state_d = SEQ_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (cnt_q == CNT_W'(2 * WIDTH - 1)) begin
                        state_d = SEQ_FINISH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            SEQ_FINISH: begin
                state_d = SEQ_IDLE;
                if (!abort) begin
                    result_d = fin_res;
                    error_d  = fin_err;
                    done_d   = 1'b1;
                end
            end

            default: state_d = SEQ_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= SEQ_IDLE;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
            error_q   <= error_d;
            done_q    <= done_d;
        end
    end

    assign busy   = (state_q != SEQ_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign error  = error_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer at WIDTH=16: stimulus pushes the
// expected {result, error, completion edge}; a monitor pops on every done.
module tb_alu_sequencer;
    import calc_pkg::*;

    localparam int W   = 16;
    localparam int LAT = 3 * W + 1;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [1:0]          op = 2'd0;
    logic signed [W-1:0] operand_a = '0;
    logic signed [W-1:0] operand_b = '0;
    logic                abort = 1'b0;
    logic                busy;
    logic                done;
    logic signed [W-1:0] result;
    logic                error;

    typedef struct {
        logic signed [W-1:0] res;
        logic                err;
        int                  edge_no;
        string               name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    alu_sequencer #(
        .WIDTH      (W),
        .FRAC_SCALE (100)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .error     (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt++;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at edge %0d, required 0", edge_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_result"}, longint'(result), longint'(mon_e.res));
                chk({mon_e.name, "_error"}, longint'(error), longint'(mon_e.err));
                chk({mon_e.name, "_edge"}, longint'(edge_cnt), longint'(mon_e.edge_no));
            end
        end
    end

    // Issue one request; afterwards scramble the inputs, which must not matter.
    task automatic issue(input logic [1:0] o, input logic signed [W-1:0] a,
                         input logic signed [W-1:0] b, input logic signed [W-1:0] er,
                         input logic ee, input int lat, input string nm);
        @(negedge clock);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        exp_q.push_back('{er, ee, edge_cnt + 1 + lat, nm});
        @(negedge clock);
        start = 1'b0;
        op = ~o; operand_a = 16'sh1234; operand_b = '0;
        chk({nm, "_busy"}, longint'(busy), (lat != 0) ? 1 : 0);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk({nm, "_outstanding"}, longint'(exp_q.size()), 0);
        exp_q.delete();
        chk({nm, "_busy_after"}, longint'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_result", longint'(result), 0);
        chk("reset_error", longint'(error), 0);
        reset = 1'b0;

        issue(ALU_ADD, -16'sd325, 16'sd100, -16'sd225, 1'b0, 0, "add");
        drain("add");
        issue(ALU_SUB, 16'sd100, -16'sd325, 16'sd425, 1'b0, 0, "sub");
        drain("sub");
        issue(ALU_ADD, 16'sd32000, 16'sd1000, -16'sd32536, 1'b1, 0, "add_ovf");
        drain("add_ovf");
        issue(ALU_SUB, -16'sd32000, 16'sd1000, 16'sd32536, 1'b1, 0, "sub_ovf");
        drain("sub_ovf");

        // mul with a start pulse while busy that must be ignored
        issue(ALU_MUL, 16'sd150, 16'sd200, 16'sd300, 1'b0, LAT, "mul");
        repeat (5) @(negedge clock);
        op = ALU_ADD; operand_a = 16'sd1; operand_b = 16'sd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain("mul");

        issue(ALU_MUL, -16'sd250, 16'sd300, -16'sd750, 1'b0, LAT, "mul_neg");
        drain("mul_neg");
        issue(ALU_DIV, -16'sd700, 16'sd200, -16'sd350, 1'b0, LAT, "div_neg");
        drain("div_neg");
`ifdef ALU_SEQUENCER_ROUND_EN
        issue(ALU_DIV, 16'sd200, 16'sd300, 16'sd67, 1'b0, LAT, "div_frac");
`else
        issue(ALU_DIV, 16'sd200, 16'sd300, 16'sd66, 1'b0, LAT, "div_frac");
`endif
        drain("div_frac");
        issue(ALU_DIV, 16'sd500, 16'sd0, 16'sd0, 1'b1, 0, "div_zero");
        drain("div_zero");
        issue(ALU_MUL, 16'sd16384, 16'sd400, 16'sd32767, 1'b1, LAT, "mul_sat_pos");
        drain("mul_sat_pos");
        issue(ALU_MUL, -16'sd16384, 16'sd400, -16'sd32768, 1'b1, LAT, "mul_sat_neg");
        drain("mul_sat_neg");
        issue(ALU_ADD, 16'sd100, 16'sd100, 16'sd200, 1'b0, 0, "add_after_sat");
        drain("add_after_sat");

        // abort during MUL: back to IDLE, no done, outputs held
        @(negedge clock);
        op = ALU_MUL; operand_a = 16'sd300; operand_b = 16'sd300; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_busy", longint'(busy), 0);
        repeat (60) @(negedge clock);
        chk("abort_result", longint'(result), 200);
        chk("abort_error", longint'(error), 0);

        // abort and start together in IDLE: request dropped
        op = ALU_ADD; operand_a = 16'sd7; operand_b = 16'sd7; start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_done", longint'(done), 0);
        chk("abort_start_busy", longint'(busy), 0);
        @(negedge clock);
        chk("abort_start_result", longint'(result), 200);

        // reset asserted while in the DIV phase
        op = ALU_MUL; operand_a = 16'sd150; operand_b = 16'sd200; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (25) @(negedge clock);
        chk("pre_reset_busy", longint'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_done", longint'(done), 0);
        chk("midrst_result", longint'(result), 0);
        chk("midrst_error", longint'(error), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("post_reset_idle_done", longint'(done), 0);
        issue(ALU_ADD, 16'sd150, -16'sd50, 16'sd100, 1'b0, 0, "add_post_reset");
        drain("add_post_reset");

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
